// File: rtl/ex_mem_wb_pipe_pkg.sv
// Shared definitions for the EX/MEM and MEM/WB pipeline register bank:
// default datapath widths and the packed control word carried down the pipe.
package ex_mem_wb_pipe_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_AW = 5;
   localparam int DEF_CNT_W  = 32;

   // Control bits that travel with an instruction from EX into MEM
   typedef struct packed {
      logic regWrite;
      logic memToReg;
      logic memRead;
      logic memWrite;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // Bubble encoding: no register write, no memory access
   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ex_mem_wb_pipe_if.sv
// Signal bundle between the EX stage / data memory / forwarding logic and the
// EX/MEM-MEM/WB register bank. The register bank uses the slave view; whoever
// drives EX results and memory read data uses the master view.
interface ex_mem_wb_pipe_if
   import ex_mem_wb_pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW,
   parameter int CNT_W  = DEF_CNT_W
);

   logic              ex_valid;
   logic              ex_reg_write;
   logic              ex_mem_to_reg;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic [REG_AW-1:0] ex_write_register;
   logic [DATA_W-1:0] ex_alu_result;
   logic [DATA_W-1:0] ex_store_data;
   logic              flush_ex;
   logic              mem_stall;
   logic [DATA_W-1:0] mem_read_data;

   logic              MEM_RegWrite;
   logic [REG_AW-1:0] MEM_WriteRegister;
   logic              MEM_MemRead;
   logic              MEM_MemWrite;
   logic [DATA_W-1:0] MEM_ALUResult;
   logic [DATA_W-1:0] MEM_StoreData;
   logic              WB_RegWrite;
   logic [REG_AW-1:0] WB_WriteRegister;
   logic [DATA_W-1:0] WB_WriteData;
   logic              pipe_hold;
   logic [CNT_W-1:0]  retired_count;

   modport master (
      output ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
      output ex_write_register, ex_alu_result, ex_store_data,
      output flush_ex, mem_stall, mem_read_data,
      input  MEM_RegWrite, MEM_WriteRegister, MEM_MemRead, MEM_MemWrite,
      input  MEM_ALUResult, MEM_StoreData,
      input  WB_RegWrite, WB_WriteRegister, WB_WriteData,
      input  pipe_hold, retired_count
   );

   modport slave (
      input  ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
      input  ex_write_register, ex_alu_result, ex_store_data,
      input  flush_ex, mem_stall, mem_read_data,
      output MEM_RegWrite, MEM_WriteRegister, MEM_MemRead, MEM_MemWrite,
      output MEM_ALUResult, MEM_StoreData,
      output WB_RegWrite, WB_WriteRegister, WB_WriteData,
      output pipe_hold, retired_count
   );

endinterface

// File: rtl/ex_mem_wb_pipe_stage_reg.sv
// Generic pipeline stage register: a valid bit plus a flat payload, with a
// hold input that freezes everything and a bubble input that clears only the
// valid bit. Payload still loads on a bubble; consumers qualify it by valid.
module pipe_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_hold,
   input  logic         i_bubble,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // Capture the upstream instruction unless held; a bubble keeps the data
   // but marks the slot empty. Reset empties the slot and zeroes the payload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (!i_hold) begin
         r_valid <= i_valid & ~i_bubble;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline register bank of the 5-stage MIPS core.
// Carries EX results through MEM into WB, picks the write-back value, exposes
// the MEM/WB destination info used by forwarding, freezes on a data-memory
// stall, squashes flushed EX instructions and counts retired instructions.
module ex_mem_wb_pipe
   import ex_mem_wb_pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW,
   parameter int CNT_W  = DEF_CNT_W
) (
   input logic          clk,
   input logic          reset_n,
   ex_mem_wb_pipe_if.slave bus
);

   localparam int EXMEM_W = CTRL_W + REG_AW + 2 * DATA_W;
   localparam int MEMWB_W = 1 + REG_AW + DATA_W;

   ctrl_t               w_exCtrl;
   ctrl_t               w_exCtrlSel;
   logic [EXMEM_W-1:0]  w_exMemD;
   logic [EXMEM_W-1:0]  w_exMemQ;
   logic                w_memValid;
   ctrl_t               w_memCtrl;
   logic [REG_AW-1:0]   w_memWr;
   logic [DATA_W-1:0]   w_memAlu;
   logic [DATA_W-1:0]   w_memStore;
   logic [DATA_W-1:0]   w_wbDataSel;
   logic [MEMWB_W-1:0]  w_memWbD;
   logic [MEMWB_W-1:0]  w_memWbQ;
   logic                w_wbValid;
   logic                w_wbRegWrite;
   logic [REG_AW-1:0]   w_wbWr;
   logic [DATA_W-1:0]   w_wbData;
   logic [CNT_W-1:0]    r_retiredCount;

   // A flushed instruction also carries the NOP control word so that nothing
   // downstream ever sees stale write enables, even before valid gating.
   assign w_exCtrl    = '{regWrite: bus.ex_reg_write, memToReg: bus.ex_mem_to_reg,
                          memRead:  bus.ex_mem_read,  memWrite: bus.ex_mem_write};
   assign w_exCtrlSel = bus.flush_ex ? CTRL_NOP : w_exCtrl;
   assign w_exMemD    = {w_exCtrlSel, bus.ex_write_register, bus.ex_alu_result, bus.ex_store_data};

   // EX/MEM: stall freezes it, and since hold wins inside the stage register
   // a flush arriving during a stall has no effect until the stall clears.
   pipe_stage_reg #(.W(EXMEM_W)) u_exMem (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_hold   (bus.mem_stall),
      .i_bubble (bus.flush_ex),
      .i_valid  (bus.ex_valid),
      .i_data   (w_exMemD),
      .o_valid  (w_memValid),
      .o_data   (w_exMemQ)
   );

   assign {w_memCtrl, w_memWr, w_memAlu, w_memStore} = w_exMemQ;

   // Loads take data memory's read data, everything else the ALU result.
   assign w_wbDataSel = w_memCtrl.memToReg ? bus.mem_read_data : w_memAlu;
   assign w_memWbD    = {w_memCtrl.regWrite, w_memWr, w_wbDataSel};

   // MEM/WB: the instruction in MEM is never squashed, only held.
   pipe_stage_reg #(.W(MEMWB_W)) u_memWb (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_hold   (bus.mem_stall),
      .i_bubble (1'b0),
      .i_valid  (w_memValid),
      .i_data   (w_memWbD),
      .o_valid  (w_wbValid),
      .o_data   (w_memWbQ)
   );

   assign {w_wbRegWrite, w_wbWr, w_wbData} = w_memWbQ;

   // An instruction retires when it leaves WB, which only happens on an
   // unstalled edge; the count wraps naturally at its width.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_retiredCount <= '0;
      end else if (!bus.mem_stall) begin
         r_retiredCount <= r_retiredCount + CNT_W'(w_wbValid);
      end
   end

   // The store enable stays up through a stall: memory accepts the write on
   // the edge where it stops stalling, so the request must persist until then.
   assign bus.MEM_RegWrite      = w_memValid & w_memCtrl.regWrite;
   assign bus.MEM_WriteRegister = w_memWr;
   assign bus.MEM_MemRead       = w_memValid & w_memCtrl.memRead;
   assign bus.MEM_MemWrite      = w_memValid & w_memCtrl.memWrite;
   assign bus.MEM_ALUResult     = w_memAlu;
   assign bus.MEM_StoreData     = w_memStore;
   assign bus.WB_RegWrite       = w_wbValid & w_wbRegWrite;
   assign bus.WB_WriteRegister  = w_wbWr;
   assign bus.WB_WriteData      = w_wbData;
   assign bus.pipe_hold         = bus.mem_stall;
   assign bus.retired_count     = r_retiredCount;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed bench for ex_mem_wb_pipe. Register-writing instructions are queued
// as they are driven into EX and compared when they show up in WB; a small
// valid-bit model tracks the expected retired count every cycle. A narrow
// counter width lets the wrap be reached by real traffic.
module tb_ex_mem_wb_pipe;

   localparam int TB_DATA_W = 32;
   localparam int TB_REG_AW = 5;
   localparam int TB_CNT_W  = 6;

   typedef struct {
      logic [TB_REG_AW-1:0] wr;
      logic [TB_DATA_W-1:0] data;
   } wbExp_t;

   logic   clk = 1'b0;
   logic   reset_n = 1'b0;
   int     testCount = 0;
   int     failCount = 0;
   wbExp_t sb[$];
   wbExp_t monExp;
   logic   mRst, mStall, mExLive;
   logic   modelMem = 1'b0;
   logic   modelWb = 1'b0;
   logic [TB_CNT_W-1:0] expRetired = '0;
   logic [TB_CNT_W-1:0] startCount;

   // Free-running core clock
   always #5 clk = ~clk;

   ex_mem_wb_pipe_if #(.DATA_W(TB_DATA_W), .REG_AW(TB_REG_AW), .CNT_W(TB_CNT_W)) tbIf ();

   ex_mem_wb_pipe #(.DATA_W(TB_DATA_W), .REG_AW(TB_REG_AW), .CNT_W(TB_CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (tbIf)
   );

   // Data memory model: the word at an address is the address XOR a pattern
   assign tbIf.mem_read_data = tbIf.MEM_ALUResult ^ 32'hDEADBEEF;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic regWrite, input logic memToReg,
                                input logic memRead, input logic memWrite,
                                input logic [TB_REG_AW-1:0] wr, input logic [TB_DATA_W-1:0] alu,
                                input logic [TB_DATA_W-1:0] store, input logic flush);
      wbExp_t e;
      tbIf.ex_valid          = valid;
      tbIf.ex_reg_write      = regWrite;
      tbIf.ex_mem_to_reg     = memToReg;
      tbIf.ex_mem_read       = memRead;
      tbIf.ex_mem_write      = memWrite;
      tbIf.ex_write_register = wr;
      tbIf.ex_alu_result     = alu;
      tbIf.ex_store_data     = store;
      tbIf.flush_ex          = flush;
      if (valid && regWrite && !flush) begin
         e.wr   = wr;
         e.data = memToReg ? (alu ^ 32'hDEADBEEF) : alu;
         sb.push_back(e);
      end
   endtask

   task automatic bubble();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle monitor: advance the valid-bit model on each edge, then check
   // the retired count and pop the scoreboard when a new write reaches WB.
   always begin
      @(posedge clk);
      mRst    = reset_n;
      mStall  = tbIf.mem_stall;
      mExLive = tbIf.ex_valid & ~tbIf.flush_ex;
      if (!mRst) begin
         modelMem   = 1'b0;
         modelWb    = 1'b0;
         expRetired = '0;
      end else if (!mStall) begin
         expRetired = expRetired + TB_CNT_W'(modelWb);
         modelWb    = modelMem;
         modelMem   = mExLive;
      end
      #1;
      if (mRst && reset_n) begin
         checkOutput("retired_count", 64'(tbIf.retired_count), 64'(expRetired));
         if (!mStall && tbIf.WB_RegWrite) begin
            if (sb.size() == 0) begin
               checkOutput("wb_unexpected_write", 64'(tbIf.WB_RegWrite), 64'(1'b0));
            end else begin
               monExp = sb.pop_front();
               checkOutput("wb_reg", 64'(tbIf.WB_WriteRegister), 64'(monExp.wr));
               checkOutput("wb_data", 64'(tbIf.WB_WriteData), 64'(monExp.data));
            end
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence
   initial begin
      tbIf.mem_stall = 1'b0;
      bubble();
      reset_n = 1'b0;
      tick();
      tick();
      checkOutput("rst_mem_regwrite", 64'(tbIf.MEM_RegWrite), 64'(0));
      checkOutput("rst_mem_wr", 64'(tbIf.MEM_WriteRegister), 64'(0));
      checkOutput("rst_wb_regwrite", 64'(tbIf.WB_RegWrite), 64'(0));
      checkOutput("rst_wb_data", 64'(tbIf.WB_WriteData), 64'(0));
      checkOutput("rst_retired", 64'(tbIf.retired_count), 64'(0));
      reset_n = 1'b1;

      // ALU operation: one cycle to MEM, two to WB, retired the cycle after
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0, 1'b0);
      tick();
      bubble();
      checkOutput("alu_mem_regwrite", 64'(tbIf.MEM_RegWrite), 64'(1));
      checkOutput("alu_mem_wr", 64'(tbIf.MEM_WriteRegister), 64'(5));
      checkOutput("alu_mem_result", 64'(tbIf.MEM_ALUResult), 64'h1234);
      checkOutput("alu_mem_memread", 64'(tbIf.MEM_MemRead), 64'(0));
      tick();
      checkOutput("alu_wb_regwrite", 64'(tbIf.WB_RegWrite), 64'(1));
      checkOutput("alu_wb_data", 64'(tbIf.WB_WriteData), 64'h1234);
      checkOutput("alu_retired_before", 64'(tbIf.retired_count), 64'(0));
      tick();
      checkOutput("alu_retired_after", 64'(tbIf.retired_count), 64'(1));
      checkOutput("alu_wb_empty", 64'(tbIf.WB_RegWrite), 64'(0));

      // Load: address 0 reads 0xDEADBEEF from the memory model
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 32'h0, 32'h0, 1'b0);
      tick();
      bubble();
      checkOutput("ld_mem_memread", 64'(tbIf.MEM_MemRead), 64'(1));
      checkOutput("ld_mem_regwrite", 64'(tbIf.MEM_RegWrite), 64'(1));
      tick();
      checkOutput("ld_wb_data", 64'(tbIf.WB_WriteData), 64'hDEADBEEF);
      checkOutput("ld_wb_wr", 64'(tbIf.WB_WriteRegister), 64'(8));
      tick();

      // Store: memory write request and store data in MEM, no WB write
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h100, 32'hCAFE, 1'b0);
      tick();
      bubble();
      checkOutput("st_mem_memwrite", 64'(tbIf.MEM_MemWrite), 64'(1));
      checkOutput("st_mem_storedata", 64'(tbIf.MEM_StoreData), 64'hCAFE);
      checkOutput("st_mem_addr", 64'(tbIf.MEM_ALUResult), 64'h100);
      checkOutput("st_mem_regwrite", 64'(tbIf.MEM_RegWrite), 64'(0));
      tick();
      checkOutput("st_wb_regwrite", 64'(tbIf.WB_RegWrite), 64'(0));
      tick();

      // Stall with r2 in WB and r3 in MEM, r4 waiting in EX
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h22, 32'h0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h33, 32'h0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h44, 32'h0, 1'b0);
      tbIf.mem_stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput("stl_mem_regwrite", 64'(tbIf.MEM_RegWrite), 64'(1));
         checkOutput("stl_mem_wr", 64'(tbIf.MEM_WriteRegister), 64'(3));
         checkOutput("stl_mem_result", 64'(tbIf.MEM_ALUResult), 64'h33);
         checkOutput("stl_wb_regwrite", 64'(tbIf.WB_RegWrite), 64'(1));
         checkOutput("stl_wb_wr", 64'(tbIf.WB_WriteRegister), 64'(2));
         checkOutput("stl_wb_data", 64'(tbIf.WB_WriteData), 64'h22);
         checkOutput("stl_pipe_hold", 64'(tbIf.pipe_hold), 64'(1));
      end
      tbIf.mem_stall = 1'b0;
      tick();
      bubble();
      checkOutput("stl_rel_mem_wr", 64'(tbIf.MEM_WriteRegister), 64'(4));
      checkOutput("stl_rel_wb_wr", 64'(tbIf.WB_WriteRegister), 64'(3));
      checkOutput("stl_rel_wb_data", 64'(tbIf.WB_WriteData), 64'h33);
      checkOutput("stl_rel_pipe_hold", 64'(tbIf.pipe_hold), 64'(0));
      tick();
      tick();
      tick();

      // Flush of a valid register-writing store loads a bubble
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99, 32'h5, 1'b1);
      tick();
      bubble();
      checkOutput("fl_mem_regwrite", 64'(tbIf.MEM_RegWrite), 64'(0));
      checkOutput("fl_mem_memwrite", 64'(tbIf.MEM_MemWrite), 64'(0));
      tick();
      checkOutput("fl_wb_regwrite", 64'(tbIf.WB_RegWrite), 64'(0));

      // Flush during a stall: MEM keeps r10; r11 is squashed on release
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 32'hAA, 32'h0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 32'hBB, 32'h0, 1'b1);
      tbIf.mem_stall = 1'b1;
      tick();
      checkOutput("flst_mem_regwrite", 64'(tbIf.MEM_RegWrite), 64'(1));
      checkOutput("flst_mem_wr", 64'(tbIf.MEM_WriteRegister), 64'(10));
      tbIf.mem_stall = 1'b0;
      tick();
      bubble();
      checkOutput("flst_rel_mem_regwrite", 64'(tbIf.MEM_RegWrite), 64'(0));
      checkOutput("flst_rel_wb_wr", 64'(tbIf.WB_WriteRegister), 64'(10));
      checkOutput("flst_rel_wb_regwrite", 64'(tbIf.WB_RegWrite), 64'(1));
      tick();
      tick();
      tick();

      // Reset in the middle of traffic clears everything at once
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 32'hC0, 32'h0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd13, 32'hD0, 32'h0, 1'b0);
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("mrst_mem_regwrite", 64'(tbIf.MEM_RegWrite), 64'(0));
      checkOutput("mrst_mem_wr", 64'(tbIf.MEM_WriteRegister), 64'(0));
      checkOutput("mrst_mem_result", 64'(tbIf.MEM_ALUResult), 64'(0));
      checkOutput("mrst_wb_regwrite", 64'(tbIf.WB_RegWrite), 64'(0));
      checkOutput("mrst_wb_wr", 64'(tbIf.WB_WriteRegister), 64'(0));
      checkOutput("mrst_wb_data", 64'(tbIf.WB_WriteData), 64'(0));
      checkOutput("mrst_retired", 64'(tbIf.retired_count), 64'(0));
      sb.delete();
      bubble();
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tick();

      // Counter wrap: retire 70 instructions through a 6-bit counter
      startCount = expRetired;
      for (int i = 0; i < 70; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'((i % 31) + 1), 32'(i * 3 + 7), 32'h0, 1'b0);
         tick();
      end
      bubble();
      tick();
      tick();
      tick();
      checkOutput("wrap_retired", 64'(tbIf.retired_count), 64'(startCount + 6'd6));
      checkOutput("scoreboard_empty", 64'(sb.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
